// File: rtl/promotion_ctrl.sv
// Pawn-promotion menu: a four-piece selection FSM driven by keyboard pulses, plus a
// two-stage pixel pipeline that addresses the promotion sprite ROM and highlights the cursor tile.
module promotion_ctrl #(
    parameter int BOX_X    = 224,
    parameter int BOX_Y    = 216,
    parameter int TILE     = 48,
    parameter int HL_INDEX = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        promo_req,
    input  logic        promo_color,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_enter,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [14:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [3:0]  pal_index,
    output logic        overlay_on,
    output logic        busy,
    output logic        done,
    output logic [1:0]  piece
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SELECT  = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam logic [9:0]  X_LO      = 10'(BOX_X);
    localparam logic [9:0]  X_HI      = 10'(BOX_X + 4 * TILE - 1);
    localparam logic [9:0]  Y_LO      = 10'(BOX_Y);
    localparam logic [9:0]  Y_HI      = 10'(BOX_Y + TILE - 1);
    localparam logic [9:0]  T1        = 10'(TILE);
    localparam logic [9:0]  T2        = 10'(2 * TILE);
    localparam logic [9:0]  T3        = 10'(3 * TILE);
    localparam logic [14:0] TILE_W    = 15'(TILE);
    localparam logic [14:0] TILE_AREA = 15'(TILE * TILE);
    localparam logic [3:0]  HL        = 4'(HL_INDEX);

    logic [1:0]  state_r;
    logic [1:0]  cursor_r;
    logic        color_r;
    logic [1:0]  piece_r;
    logic        done_r;
    logic        busy_r;

    logic [14:0] rom_addr_r;
    logic        inbox_r;
    logic        sel_r;
    logic        overlay_on_r;
    logic [3:0]  pal_index_r;

    logic [9:0]  rx_s;
    logic [9:0]  ry_s;
    logic [9:0]  tx_s;
    logic [1:0]  tile_s;
    logic        inbox_s;
    logic        sel_s;
    logic [14:0] addr_s;
    logic [14:0] addr_next_s;
    logic [3:0]  pal_next_s;

    // Tile decode by comparison so no divider is needed.
    function automatic logic [1:0] tile_of(input logic [9:0] rx);
        logic [1:0] t;
        if (rx < T1) begin
            t = 2'd0;
        end else if (rx < T2) begin
            t = 2'd1;
        end else if (rx < T3) begin
            t = 2'd2;
        end else begin
            t = 2'd3;
        end
        return t;
    endfunction

    function automatic logic [9:0] tile_base(input logic [1:0] t);
        logic [9:0] b;
        case (t)
            2'd0:    b = 10'd0;
            2'd1:    b = T1;
            2'd2:    b = T2;
            2'd3:    b = T3;
            default: b = 10'd0;
        endcase
        return b;
    endfunction

    // Menu FSM; enter wins over cursor moves, opposing moves cancel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= IDLE;
            cursor_r <= 2'd0;
            color_r  <= 1'b0;
            piece_r  <= 2'd0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (promo_req) begin
                        color_r  <= promo_color;
                        cursor_r <= 2'd0;
                        busy_r   <= 1'b1;
                        state_r  <= SELECT;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                SELECT: begin
                    busy_r <= 1'b1;
                    if (key_enter) begin
                        piece_r <= cursor_r;
                        done_r  <= 1'b1;
                        state_r <= DONE_ST;
                    end else if (key_left && !key_right) begin
                        cursor_r <= cursor_r - 2'd1;
                    end else if (key_right && !key_left) begin
                        cursor_r <= cursor_r + 2'd1;
                    end else begin
                        cursor_r <= cursor_r;
                    end
                end
                DONE_ST: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stage-0 geometry and sprite address for the current pixel.
    always_comb begin
        rx_s    = DrawX - X_LO;
        ry_s    = DrawY - Y_LO;
        inbox_s = busy_r && (DrawX >= X_LO) && (DrawX <= X_HI) &&
                  (DrawY >= Y_LO) && (DrawY <= Y_HI);
        tile_s  = tile_of(rx_s);
        tx_s    = rx_s - tile_base(tile_s);
        sel_s   = (tile_s == cursor_r);
        addr_s  = 15'({color_r, tile_s}) * TILE_AREA + 15'(ry_s) * TILE_W + 15'(tx_s);
        if (inbox_s) begin
            addr_next_s = addr_s;
        end else begin
            addr_next_s = 15'd0;
        end
    end

    // Stage-1 palette selection; background of the selected tile is highlighted.
    always_comb begin
        if (!inbox_r) begin
            pal_next_s = 4'd0;
        end else if (sel_r && (rom_data == 4'd0)) begin
            pal_next_s = HL;
        end else begin
            pal_next_s = rom_data;
        end
    end

    // Pixel pipeline registers (ROM address at stage 0, palette output at stage 1).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_r   <= 15'd0;
            inbox_r      <= 1'b0;
            sel_r        <= 1'b0;
            overlay_on_r <= 1'b0;
            pal_index_r  <= 4'd0;
        end else begin
            rom_addr_r   <= addr_next_s;
            inbox_r      <= inbox_s;
            sel_r        <= sel_s;
            overlay_on_r <= inbox_r;
            pal_index_r  <= pal_next_s;
        end
    end

    assign rom_addr   = rom_addr_r;
    assign pal_index  = pal_index_r;
    assign overlay_on = overlay_on_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign piece      = piece_r;

endmodule

// File: tb/tb_promotion_ctrl.sv
// Directed bench for promotion_ctrl: menu sequences by hand, pixel pipeline from a vector table.
module tb_promotion_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        promo_req = 1'b0;
    logic        promo_color = 1'b0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic        key_enter = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic [3:0]  pal_index;
    logic        overlay_on;
    logic        busy;
    logic        done;
    logic [1:0]  piece;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic color;
        int   cur;
        int   dx;
        int   dy;
        int   rd;
        int   addr;
        int   ov;
        int   pal;
    } pix_vec_t;

    pix_vec_t vecs [9];

    promotion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .promo_req(promo_req), .promo_color(promo_color),
        .key_left(key_left), .key_right(key_right), .key_enter(key_enter),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
        .pal_index(pal_index), .overlay_on(overlay_on), .busy(busy), .done(done),
        .piece(piece)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic close_menu();
        if (busy) begin
            key_enter = 1'b1;
            step();
            key_enter = 1'b0;
            step();
        end
    endtask

    task automatic open_menu(input logic c, input int cur);
        close_menu();
        promo_color = c;
        promo_req   = 1'b1;
        step();
        promo_req   = 1'b0;
        for (int i = 0; i < cur; i++) begin
            key_right = 1'b1;
            step();
        end
        key_right = 1'b0;
    endtask

    task automatic pixel(input int dx, input int dy, input int rd,
                         input int exp_addr, input int exp_ov, input int exp_pal);
        DrawX    = 10'(dx);
        DrawY    = 10'(dy);
        rom_data = 4'(rd);
        step();
        chk("rom_addr", int'(rom_addr), exp_addr);
        step();
        chk("overlay_on", int'(overlay_on), exp_ov);
        chk("pal_index", int'(pal_index), exp_pal);
        DrawX    = 10'd0;
        DrawY    = 10'd0;
        rom_data = 4'd0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 0, 324, 221, 7, 14068, 1, 7};
        vecs[1] = '{1'b0, 1, 274, 226, 0, 2786,  1, 3};
        vecs[2] = '{1'b0, 1, 324, 226, 0, 5092,  1, 0};
        vecs[3] = '{1'b0, 1, 416, 226, 5, 0,     0, 0};
        vecs[4] = '{1'b0, 1, 274, 215, 5, 0,     0, 0};
        vecs[5] = '{1'b1, 3, 415, 263, 0, 18431, 1, 3};
        vecs[6] = '{1'b0, 0, 224, 216, 9, 0,     1, 9};
        vecs[7] = '{1'b0, 2, 320, 263, 0, 6864,  1, 3};
        vecs[8] = '{1'b0, 3, 367, 216, 0, 4655,  1, 0};

        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst piece", int'(piece), 0);
        chk("rst overlay_on", int'(overlay_on), 0);
        chk("rst pal_index", int'(pal_index), 0);
        chk("rst rom_addr", int'(rom_addr), 0);
        Reset = 1'b0;
        step();

        // Basic selection: right, right, enter.
        open_menu(1'b0, 2);
        chk("sel busy", int'(busy), 1);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        chk("basic done", int'(done), 1);
        chk("basic busy in done", int'(busy), 1);
        chk("basic piece", int'(piece), 2);
        step();
        chk("basic done width", int'(done), 0);
        chk("basic busy drop", int'(busy), 0);

        // Reset mid-menu with cursor 2.
        open_menu(1'b0, 2);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort piece", int'(piece), 0);
        chk("abort overlay_on", int'(overlay_on), 0);
        step();
        chk("abort done later", int'(done), 0);

        // Left wrap 0 -> 3.
        open_menu(1'b0, 0);
        key_left = 1'b1;
        step();
        key_left = 1'b0;
        close_menu();
        chk("left wrap piece", int'(piece), 3);

        // Right wrap 3 -> 0.
        open_menu(1'b0, 3);
        key_right = 1'b1;
        step();
        key_right = 1'b0;
        close_menu();
        chk("right wrap piece", int'(piece), 0);

        // Enter with right at cursor 1 takes the pre-move cursor.
        open_menu(1'b0, 1);
        key_enter = 1'b1;
        key_right = 1'b1;
        step();
        key_enter = 1'b0;
        key_right = 1'b0;
        chk("enter+right piece", int'(piece), 1);
        step();

        // Left and right together do not move.
        open_menu(1'b0, 2);
        key_left  = 1'b1;
        key_right = 1'b1;
        step();
        key_left  = 1'b0;
        key_right = 1'b0;
        close_menu();
        chk("left+right piece", int'(piece), 2);

        // promo_req inside SELECT must not reload color or cursor.
        open_menu(1'b1, 3);
        promo_color = 1'b0;
        promo_req   = 1'b1;
        step();
        promo_req   = 1'b0;
        chk("req in select busy", int'(busy), 1);
        pixel(234, 216, 0, 9226, 1, 0);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        chk("req in select piece", int'(piece), 3);
        // promo_req during DONE is ignored.
        promo_req = 1'b1;
        step();
        promo_req = 1'b0;
        chk("req in done busy", int'(busy), 0);
        step();
        chk("req in done stays idle", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            open_menu(vecs[i].color, vecs[i].cur);
            pixel(vecs[i].dx, vecs[i].dy, vecs[i].rd, vecs[i].addr, vecs[i].ov, vecs[i].pal);
        end

        // Menu closed: in-box pixel is no longer part of the overlay.
        close_menu();
        pixel(324, 221, 7, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
